out_channel_checker: RTL and testbench

// Downstream consumer of the test program's out channel. Accepts output words via

---
 rtl/out_channel_checker_if.sv | 11 +
 rtl/out_channel_checker.sv | 151 +++++++++++++++
 tb/tb_out_channel_checker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/out_channel_checker_if.sv
// Valid/ready word channel from the test program's out port into the checker.
interface out_channel_checker_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/out_channel_checker.sv
// Buffers program output words in a small FIFO and checks them, in order, against
// an expected sequence; reports a finished/success verdict bounded by a step timeout.
module out_channel_checker #(
  parameter int                            WIDTH         = 12,
  parameter int                            DEPTH         = 4,
  parameter int                            EXPECT_COUNT  = 1,
  parameter logic [EXPECT_COUNT*WIDTH-1:0] EXPECT_VALUES = 12'd5,
  parameter int                            MAX_STEPS     = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  out_channel_checker_if.slave ch,
  output logic                 finished,
  output logic                 success,
  output logic [7:0]           received,
  output logic [7:0]           mismatches,
  output logic [7:0]           first_bad
);
  localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [7:0]       EXP_CNT   = 8'(EXPECT_COUNT);
  localparam logic [15:0]      LAST_STEP = 16'(MAX_STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [15:0]        step_reg, step_next;
  logic [7:0]         compared_reg, compared_next, received_reg, received_next;
  logic [7:0]         mismatches_reg, mismatches_next, first_bad_reg, first_bad_next;
  logic               success_reg, success_next, in_ready_reg, in_ready_next;
  logic               push, pop, bad, done_ok, restart;
  logic [WIDTH-1:0]   head;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   expected [256];

  // Full 256-entry table so the 8-bit compare index never runs out of range.
  for (genvar gi = 0; gi < 256; gi++) begin : g_expected
    if (gi < EXPECT_COUNT) begin : g_used
      assign expected[gi] = EXPECT_VALUES[gi*WIDTH +: WIDTH];
    end else begin : g_unused
      assign expected[gi] = '0;
    end
  end

  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= ch.in_data;
  end

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    count_next      = count_reg;
    step_next       = step_reg;
    compared_next   = compared_reg;
    received_next   = received_reg;
    mismatches_next = mismatches_reg;
    first_bad_next  = first_bad_reg;
    success_next    = success_reg;
    push            = 1'b0;
    pop             = 1'b0;
    bad             = 1'b0;
    done_ok         = 1'b0;
    restart         = 1'b0;
    case (state_reg)
      IDLE: restart = start;
      RUN: begin
        push      = ch.in_valid && in_ready_reg;
        pop       = (count_reg != '0);
        done_ok   = (compared_reg == EXP_CNT) && (count_reg == '0);
        bad       = pop && ((compared_reg >= EXP_CNT) || (head != expected[compared_reg]));
        step_next = step_reg + 16'd1;
        if (push) begin
          wr_ptr_next = wr_ptr_reg + PTR_W'(1);
          if (received_reg != 8'hFF) received_next = received_reg + 8'd1;
        end
        if (pop) begin
          rd_ptr_next = rd_ptr_reg + PTR_W'(1);
          if (compared_reg != 8'hFF) compared_next = compared_reg + 8'd1;
        end
        if (bad) begin
          if (mismatches_reg != 8'hFF) mismatches_next = mismatches_reg + 8'd1;
          if (first_bad_reg == 8'hFF) first_bad_next = compared_reg;
        end
        if (push && !pop)      count_next = count_reg + CNT_W'(1);
        else if (pop && !push) count_next = count_reg - CNT_W'(1);
        // No pop can happen on a done_ok edge, so mismatches_reg is already final.
        if (done_ok || (step_reg == LAST_STEP)) begin
          state_next   = DONE;
          success_next = done_ok && (mismatches_reg == 8'd0);
        end
      end
      DONE:    restart = start;
      default: state_next = IDLE;
    endcase
    if (restart) begin
      state_next      = RUN;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      count_next      = '0;
      step_next       = '0;
      compared_next   = '0;
      received_next   = '0;
      mismatches_next = '0;
      first_bad_next  = 8'hFF;
      success_next    = 1'b0;
    end
    in_ready_next = (state_next == RUN) ? (count_next < FULL_CNT) : (state_next == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      step_reg       <= '0;
      compared_reg   <= '0;
      received_reg   <= '0;
      mismatches_reg <= '0;
      first_bad_reg  <= 8'hFF;
      success_reg    <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      step_reg       <= step_next;
      compared_reg   <= compared_next;
      received_reg   <= received_next;
      mismatches_reg <= mismatches_next;
      first_bad_reg  <= first_bad_next;
      success_reg    <= success_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  assign ch.in_ready = in_ready_reg;
  assign finished    = (state_reg == DONE);
  assign success     = success_reg;
  assign received    = received_reg;
  assign mismatches  = mismatches_reg;
  assign first_bad   = first_bad_reg;
endmodule

// File: tb/tb_out_channel_checker.sv
// Bench for out_channel_checker: a default-parameter instance for the single-word,
// timeout and reset cases, and an 8-word instance driven from a vector table.
module tb_out_channel_checker;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_d = 1'b0, start_m = 1'b0;
  logic       finished_d, success_d, finished_m, success_m;
  logic [7:0] received_d, mismatches_d, first_bad_d;
  logic [7:0] received_m, mismatches_m, first_bad_m;

  out_channel_checker_if #(.WIDTH(12)) if_d ();
  out_channel_checker_if #(.WIDTH(12)) if_m ();

  always #5 clock = ~clock;

  out_channel_checker dut_d (
    .clock(clock), .reset(reset), .start(start_d), .ch(if_d),
    .finished(finished_d), .success(success_d), .received(received_d),
    .mismatches(mismatches_d), .first_bad(first_bad_d)
  );

  out_channel_checker #(
    .WIDTH(12), .DEPTH(4), .EXPECT_COUNT(8), .MAX_STEPS(64),
    .EXPECT_VALUES({12'd80, 12'd70, 12'd60, 12'd50, 12'd40, 12'd30, 12'd20, 12'd10})
  ) dut_m (
    .clock(clock), .reset(reset), .start(start_m), .ch(if_m),
    .finished(finished_m), .success(success_m), .received(received_m),
    .mismatches(mismatches_m), .first_bad(first_bad_m)
  );

  typedef struct {
    logic [11:0] data;
    logic        bad;
  } vec_t;

  vec_t tab[25];
  bit   sb[$];
  int   errors = 0;
  int   checks = 0;
  int   model_mis, model_cmp, model_rcv;
  logic [7:0] model_first;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Retire the oldest accepted word: it was compared on the edge just passed.
  task automatic pop_check(input string tag);
    bit b;
    if (sb.size() == 0) return;
    b = sb.pop_front();
    if (b) begin
      model_mis++;
      if (model_first == 8'hFF) model_first = 8'(model_cmp);
    end
    model_cmp++;
    chk({tag, "_mismatches"}, mismatches_m, model_mis);
    chk({tag, "_first_bad"}, first_bad_m, model_first);
    chk({tag, "_received"}, received_m, model_rcv);
    $display("%s: word %0d compared, mismatches=%0d first_bad=%0d", tag, model_cmp - 1,
             mismatches_m, first_bad_m);
  endtask

  task automatic run_m(input string tag, input int base, input int n, input bit timeout_run);
    int waited;
    model_mis = 0; model_cmp = 0; model_rcv = 0; model_first = 8'hFF;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    chk({tag, "_finished_after_start"}, finished_m, 0);
    for (int i = 0; i < n; i++) begin
      if_m.in_valid = 1'b1;
      if_m.in_data  = tab[base + i].data;
      chk({tag, "_in_ready"}, if_m.in_ready, 1);
      sb.push_back(tab[base + i].bad);
      model_rcv++;
      tick();
      if (i > 0) pop_check(tag);
    end
    if_m.in_valid = 1'b0;
    tick();
    pop_check(tag);
    waited = 0;
    while (!finished_m && waited < 100) begin
      tick();
      waited++;
    end
    chk({tag, "_finished"}, finished_m, 1);
    if (!timeout_run) chk({tag, "_done_latency"}, waited, 1);
    chk({tag, "_success"}, success_m, (model_mis == 0 && model_cmp == 8) ? 1 : 0);
    chk({tag, "_final_received"}, received_m, n);
    $display("%s: finished after %0d extra clocks, success=%0b", tag, waited, success_m);
  endtask

  initial begin
    if_d.in_valid = 1'b0; if_d.in_data = '0;
    if_m.in_valid = 1'b0; if_m.in_data = '0;
    for (int i = 0; i < 8; i++) begin
      tab[i]      = '{data: 12'(10 * (i + 1)), bad: 1'b0};
      tab[8 + i]  = '{data: 12'(10 * (i + 1)), bad: 1'b0};
      tab[16 + i] = '{data: 12'(10 * (i + 1)), bad: 1'b0};
    end
    tab[9]  = '{data: 12'd99, bad: 1'b1};
    tab[15] = '{data: 12'd0,  bad: 1'b1};
    tab[24] = '{data: 12'd90, bad: 1'b1};

    // Reset values
    tick(); tick();
    chk("rst_in_ready_d", if_d.in_ready, 0);
    chk("rst_finished_d", finished_d, 0);
    chk("rst_success_d", success_d, 0);
    chk("rst_received_d", received_d, 0);
    chk("rst_mismatches_d", mismatches_d, 0);
    chk("rst_first_bad_d", first_bad_d, 8'hFF);
    chk("rst_in_ready_m", if_m.in_ready, 0);
    chk("rst_first_bad_m", first_bad_m, 8'hFF);
    $display("reset: state checked");
    reset = 1'b1;
    tick();

    // Single correct word
    start_d = 1'b1; tick(); start_d = 1'b0;
    chk("t1_in_ready", if_d.in_ready, 1);
    if_d.in_valid = 1'b1; if_d.in_data = 12'd5;
    tick();
    if_d.in_valid = 1'b0;
    chk("t1_received", received_d, 1);
    chk("t1_finished_e0", finished_d, 0);
    tick();
    chk("t1_finished_e1", finished_d, 0);
    tick();
    chk("t1_finished_e2", finished_d, 1);
    chk("t1_success", success_d, 1);
    chk("t1_first_bad", first_bad_d, 8'hFF);
    $display("t1: push 5 -> finished=%0b success=%0b", finished_d, success_d);

    // Single wrong word, restarted straight from DONE
    start_d = 1'b1; tick(); start_d = 1'b0;
    chk("t2_finished_cleared", finished_d, 0);
    chk("t2_received_cleared", received_d, 0);
    chk("t2_success_cleared", success_d, 0);
    if_d.in_valid = 1'b1; if_d.in_data = 12'd6;
    tick();
    if_d.in_valid = 1'b0;
    tick();
    chk("t2_mismatches", mismatches_d, 1);
    chk("t2_first_bad", first_bad_d, 0);
    tick();
    chk("t2_finished", finished_d, 1);
    chk("t2_success", success_d, 0);
    // Late word in DONE: accepted and dropped
    if_d.in_valid = 1'b1; if_d.in_data = 12'd5;
    chk("t2_late_ready", if_d.in_ready, 1);
    tick();
    if_d.in_valid = 1'b0;
    chk("t2_late_received", received_d, 1);
    chk("t2_late_mismatches", mismatches_d, 1);
    $display("t2: push 6 -> mismatches=%0d first_bad=%0d", mismatches_d, first_bad_d);

    // Timeout with no output
    start_d = 1'b1; tick(); start_d = 1'b0;
    repeat (63) tick();
    chk("t5_not_yet", finished_d, 0);
    tick();
    chk("t5_finished", finished_d, 1);
    chk("t5_success", success_d, 0);
    chk("t5_received", received_d, 0);
    chk("t5_mismatches", mismatches_d, 0);
    start_d = 1'b1; tick(); start_d = 1'b0;
    chk("t5_restart_finished", finished_d, 0);
    chk("t5_restart_ready", if_d.in_ready, 1);
    $display("t5: timeout after 64 run clocks, restarted");

    // Reset mid-run with a word buffered
    if_d.in_valid = 1'b1; if_d.in_data = 12'd5;
    tick();
    if_d.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_in_ready", if_d.in_ready, 0);
    chk("t6_received", received_d, 0);
    chk("t6_finished", finished_d, 0);
    chk("t6_first_bad", first_bad_d, 8'hFF);
    reset = 1'b1;
    tick(); tick();
    chk("t6_idle_ready", if_d.in_ready, 0);
    chk("t6_idle_finished", finished_d, 0);
    start_d = 1'b1; tick(); start_d = 1'b0;
    if_d.in_valid = 1'b1; if_d.in_data = 12'd5;
    tick();
    if_d.in_valid = 1'b0;
    tick(); tick();
    chk("t6_rerun_finished", finished_d, 1);
    chk("t6_rerun_success", success_d, 1);
    chk("t6_rerun_mismatches", mismatches_d, 0);
    $display("t6: reset abort, clean rerun success=%0b", success_d);

    // Eight-word streams from the vector table
    run_m("m_good", 0, 8, 1'b0);
    run_m("m_bad", 8, 8, 1'b0);
    run_m("m_extra", 16, 9, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
